// File: rtl/bpu_update_queue_pkg.sv
// Purpose : shared types for the commit->BPU predictor-update path (also used by BPU and commit stage).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: PLEN, BPU_UPD_DEPTH default, bpu_update_t {pc, target, is_cond, taken, is_call, is_ret}.
package bpu_update_queue_pkg;

    localparam int PLEN          = 32;
    localparam int BPU_UPD_DEPTH = 8;

    typedef struct packed {
        logic [PLEN-1:0] pc;
        logic [PLEN-1:0] target;
        logic            is_cond;
        logic            taken;
        logic            is_call;
        logic            is_ret;
    } bpu_update_t;

endpackage

// File: rtl/bpu_update_queue_multi_push_fifo.sv
// Purpose : DEPTH-entry bpu_update_t FIFO taking up to NPUSH pre-compacted entries and popping one per cycle.
// Latency : 1 cycle write->head visible; head read combinationally from storage.
// Backpressure: none internally; the caller must not push beyond free space (checked by assertion).
// Ports   : clk_i, rst_ni (async, active-low); push_cnt_i/push_dat_i (entries 0..push_cnt_i-1 valid);
//           pop_i; head_o (entry at read pointer); count_o (registered occupancy).
module bpu_update_queue_multi_push_fifo
    import bpu_update_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NPUSH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [$clog2(NPUSH+1)-1:0]   push_cnt_i,
    input  bpu_update_t [NPUSH-1:0]      push_dat_i,
    input  logic                         pop_i,
    output bpu_update_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int PCW = $clog2(NPUSH+1);

    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [PCW-1:0] NPUSH_C = PCW'(NPUSH);

    bpu_update_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_en;

    assign pop_en  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            // Pointer arithmetic is AW bits wide, so a group straddling the end wraps for free.
            for (int j = 0; j < NPUSH; j++) begin
                if (PCW'(j) < push_cnt_i) begin
                    mem_q[wr_ptr_q + AW'(j)] <= push_dat_i[j];
                end
            end
            wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_cnt_i) - CW'(pop_en);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (count_q <= DEPTH_C)
                else $error("bpu update fifo count overflow");
            assert (push_cnt_i <= NPUSH_C)
                else $error("bpu update fifo push count too large");
        end
    end
`endif

endmodule

// File: rtl/bpu_update_queue.sv
// Purpose : compacts retired control-flow instrs in program order and streams one BPU update per cycle.
// Latency : >=1 cycle commit->update; with BPU_UPD_BYPASS_EN defined, 0 cycles when the queue is empty.
// Backpressure: commit_ready_o high only when a full group fits (registered count); update side is valid-only.
// Ports   : clk_i, rst_ni; commit_*_i per-slot retire info, commit_ready_o;
//           update_valid_o + update_{pc,target,is_cond,taken,is_call,is_ret}_o (zero when invalid);
//           occupancy_o (registered entry count).
// Option  : macro BPU_UPD_BYPASS_EN enables the empty-queue same-cycle bypass.
module bpu_update_queue
    import bpu_update_queue_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int DEPTH        = BPU_UPD_DEPTH
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid_i,
    output logic                                commit_ready_o,
    input  logic [COMMIT_WIDTH-1:0]             commit_is_br_i,
    input  logic [COMMIT_WIDTH-1:0][PLEN-1:0]   commit_pc_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_is_cond_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_taken_i,
    input  logic [COMMIT_WIDTH-1:0][PLEN-1:0]   commit_target_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_is_call_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_is_ret_i,
    output logic                                update_valid_o,
    output logic [PLEN-1:0]                     update_pc_o,
    output logic [PLEN-1:0]                     update_target_o,
    output logic                                update_is_cond_o,
    output logic                                update_taken_o,
    output logic                                update_is_call_o,
    output logic                                update_is_ret_o,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy_o
);

    localparam int CNTW = $clog2(DEPTH+1);
    localparam int PCW  = $clog2(COMMIT_WIDTH+1);
    localparam int IDXW = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    localparam logic [CNTW-1:0] READY_MAX = CNTW'(DEPTH - COMMIT_WIDTH);

    logic [CNTW-1:0]                count_q;
    logic [COMMIT_WIDTH-1:0]        acc_mask;
    logic [COMMIT_WIDTH-1:0]        push_mask;
    logic [COMMIT_WIDTH-1:0]        byp_mask;
    logic                           byp_en;
    bpu_update_t [COMMIT_WIDTH-1:0] slot_dat;
    bpu_update_t [COMMIT_WIDTH-1:0] comp_dat;
    logic [PCW-1:0]                 push_cnt;
    logic                           queue_nonempty;
    bpu_update_t                    head_dat;
    bpu_update_t                    out_dat;

    // Ready from registered count only: a same-cycle pop earns no credit.
    assign commit_ready_o = (count_q <= READY_MAX);
    assign acc_mask       = commit_valid_i & commit_is_br_i & {COMMIT_WIDTH{commit_ready_o}};
    assign queue_nonempty = (count_q != '0);

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            slot_dat[i].pc      = commit_pc_i[i];
            slot_dat[i].target  = commit_target_i[i];
            slot_dat[i].is_cond = commit_is_cond_i[i];
            slot_dat[i].taken   = commit_taken_i[i];
            slot_dat[i].is_call = commit_is_call_i[i];
            slot_dat[i].is_ret  = commit_is_ret_i[i];
        end
    end

`ifdef BPU_UPD_BYPASS_EN
    bpu_update_t byp_dat;

    // Lowest accepted slot goes straight out when nothing older is queued.
    assign byp_en   = !queue_nonempty && (acc_mask != '0);
    assign byp_mask = byp_en ? (acc_mask & (~acc_mask + COMMIT_WIDTH'(1))) : '0;

    always_comb begin
        byp_dat = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (byp_mask[i]) begin
                byp_dat = slot_dat[i];
            end
        end
    end
`else
    assign byp_en   = 1'b0;
    assign byp_mask = '0;
`endif

    assign push_mask = acc_mask & ~byp_mask;

    // Running prefix count of pushed slots gives each slot its write offset, closing holes.
    always_comb begin
        push_cnt = '0;
        comp_dat = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (push_mask[i]) begin
                comp_dat[push_cnt[IDXW-1:0]] = slot_dat[i];
                push_cnt                     = push_cnt + 1'b1;
            end
        end
    end

    bpu_update_queue_multi_push_fifo #(
        .DEPTH (DEPTH),
        .NPUSH (COMMIT_WIDTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_cnt_i (push_cnt),
        .push_dat_i (comp_dat),
        .pop_i      (queue_nonempty),
        .head_o     (head_dat),
        .count_o    (count_q)
    );

    always_comb begin
        out_dat = '0;
        if (queue_nonempty) begin
            out_dat = head_dat;
        end
`ifdef BPU_UPD_BYPASS_EN
        else if (byp_en) begin
            out_dat = byp_dat;
        end
`endif
    end

    assign update_valid_o   = queue_nonempty || byp_en;
    assign update_pc_o      = out_dat.pc;
    assign update_target_o  = out_dat.target;
    assign update_is_cond_o = out_dat.is_cond;
    assign update_taken_o   = out_dat.taken;
    assign update_is_call_o = out_dat.is_call;
    assign update_is_ret_o  = out_dat.is_ret;
    assign occupancy_o      = count_q;

endmodule
